// File: rtl/br_resolve.sv
// br_resolve: resolves EX control-flow predictions, redirects fetch on a mispredict, trains the predictor and counts accuracy
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_valid .. br_en            resolved br/jal/jalr packet from EX and its actual outcome
//   redirect_valid/pc/ready      corrected-PC handshake towards fetch
//   flush, stall_ex              kill IF/ID, hold EX while a redirect is in progress
//   upd_valid/pc/taken           one-cycle direction-predictor training pulse
//   c_total, c_mispredict        saturating counts of resolved / mispredicted predicted branches
module br_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_predicted,
    input  logic             ex_prediction,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_alt,
    input  logic             ex_jalr,
    input  logic [31:0]      ex_jalr_target,
    input  logic             br_en,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             flush,
    output logic             stall_ex,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [CNT_W-1:0] c_total,
    output logic [CNT_W-1:0] c_mispredict
);
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
    localparam int DW = $clog2(FLUSH_CYCLES + 2);
    localparam logic [DW-1:0] DRAIN_LEN = DW'(FLUSH_CYCLES);
    state_t            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [31:0]       pc_q, pc_d;
    logic              upd_valid_q, upd_valid_d;
    logic [31:0]       upd_pc_q, upd_pc_d;
    logic              upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0]  c_total_q, c_total_d;
    logic [CNT_W-1:0]  c_mis_q, c_mis_d;
    logic              accept, counted, wrong, need_redirect;
    // fetch already follows ex_target; only the other candidate can be a correction
    logic              unused_target;
    assign unused_target = ^ex_target;
    always_comb begin
        accept        = ex_valid && state_q == IDLE;
        counted       = accept && ex_predicted && !ex_jalr;
        wrong         = ex_prediction != br_en;
        need_redirect = accept && (ex_jalr || (ex_predicted && wrong));
        state_d       = state_q;
        drain_d       = drain_q;
        unique case (state_q)
            IDLE:     state_d = need_redirect ? REDIRECT : IDLE;
            REDIRECT: begin
                state_d = redirect_ready ? (FLUSH_CYCLES > 0 ? DRAIN : IDLE) : REDIRECT;
                drain_d = DRAIN_LEN;
            end
            DRAIN: begin
                state_d = drain_q <= 1 ? IDLE : DRAIN;
                drain_d = drain_q - 1'b1;
            end
            default:  state_d = IDLE;
        endcase
        // captured on entry to REDIRECT, held through the handshake, zeroed whenever IDLE is next
        pc_d        = state_d == IDLE ? '0 :
                      state_q == IDLE ? (ex_jalr ? ex_jalr_target : ex_alt) : pc_q;
        upd_valid_d = counted;
        upd_pc_d    = counted ? ex_pc : '0;
        upd_taken_d = counted && br_en;
        c_total_d   = c_total_q + CNT_W'(counted && ~&c_total_q);
        c_mis_d     = c_mis_q + CNT_W'(counted && wrong && ~&c_mis_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_q     <= '0;
            pc_q        <= '0;
            upd_valid_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            c_total_q   <= '0;
            c_mis_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            pc_q        <= pc_d;
            upd_valid_q <= upd_valid_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
            c_total_q   <= c_total_d;
            c_mis_q     <= c_mis_d;
        end
    end
    assign redirect_valid = state_q == REDIRECT;
    assign redirect_pc    = pc_q;
    assign flush          = state_q != IDLE;
    assign stall_ex       = state_q != IDLE;
    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_taken      = upd_taken_q;
    assign c_total        = c_total_q;
    assign c_mispredict   = c_mis_q;
endmodule

// File: tb/tb_br_resolve.sv
// tb_br_resolve: directed stimulus for br_resolve checked against a cycle model plus literal expectations
module tb_br_resolve;
    localparam int FC  = 2;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid = 1'b0;
    logic [31:0]   ex_pc = '0;
    logic          ex_predicted = 1'b0;
    logic          ex_prediction = 1'b0;
    logic [31:0]   ex_target = '0;
    logic [31:0]   ex_alt = '0;
    logic          ex_jalr = 1'b0;
    logic [31:0]   ex_jalr_target = '0;
    logic          br_en = 1'b0;
    logic          redirect_ready = 1'b0;
    logic          redirect_valid, flush, stall_ex, upd_valid, upd_taken;
    logic [31:0]   redirect_pc, upd_pc;
    logic [CW-1:0] c_total, c_mispredict;
    int            n_chk = 0;
    int            n_fail = 0;

    br_resolve #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_predicted(ex_predicted), .ex_prediction(ex_prediction),
        .ex_target(ex_target), .ex_alt(ex_alt), .ex_jalr(ex_jalr),
        .ex_jalr_target(ex_jalr_target), .br_en(br_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush), .stall_ex(stall_ex),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .c_total(c_total), .c_mispredict(c_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: pending redirect flag + remaining drain cycles, outcome counters as plain integers
    bit          m_redir;
    logic [31:0] m_rpc;
    int          m_drain;
    bit          m_upd;
    logic [31:0] m_upd_pc;
    bit          m_upd_taken;
    int          m_total, m_mis;

    always @(posedge clk) begin
        bit busy, acc;
        if (rst) begin
            m_redir = 0; m_rpc = '0; m_drain = 0; m_upd = 0; m_upd_pc = '0;
            m_upd_taken = 0; m_total = 0; m_mis = 0;
        end else begin
            busy        = m_redir || m_drain > 0;
            acc         = ex_valid && !busy;
            m_upd       = acc && ex_predicted && !ex_jalr;
            m_upd_pc    = m_upd ? ex_pc : '0;
            m_upd_taken = m_upd && br_en;
            if (m_upd) begin
                if (m_total < SAT) m_total++;
                if (ex_prediction != br_en && m_mis < SAT) m_mis++;
            end
            if (m_redir) begin
                if (redirect_ready) begin
                    m_redir = 0;
                    m_drain = FC;
                end
            end else if (m_drain > 0) begin
                m_drain--;
            end else if (acc && (ex_jalr || (ex_predicted && ex_prediction != br_en))) begin
                m_redir = 1;
                m_rpc   = ex_jalr ? ex_jalr_target : ex_alt;
            end
        end
    end

    always @(negedge clk) begin
        bit busy;
        busy = m_redir || m_drain > 0;
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_redir});
        chk("flush", {31'b0, flush}, {31'b0, busy});
        chk("stall_ex", {31'b0, stall_ex}, {31'b0, busy});
        chk("upd_valid", {31'b0, upd_valid}, {31'b0, m_upd});
        chk("upd_pc", upd_pc, m_upd_pc);
        chk("upd_taken", {31'b0, upd_taken}, {31'b0, m_upd_taken});
        chk("c_total", 32'(c_total), 32'(m_total));
        chk("c_mispredict", 32'(c_mispredict), 32'(m_mis));
        if (m_redir || !busy) chk("redirect_pc", redirect_pc, m_redir ? m_rpc : 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic [31:0] pc, input logic pred, input logic prd, input logic br,
                       input logic jalr, input logic [31:0] tgt, input logic [31:0] alt,
                       input logic [31:0] jt);
        ex_valid = 1'b1; ex_pc = pc; ex_predicted = pred; ex_prediction = prd; br_en = br;
        ex_jalr = jalr; ex_target = tgt; ex_alt = alt; ex_jalr_target = jt;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int fl, rv, rel;
        reset_dut();
        chk("reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("reset stall_ex", {31'b0, stall_ex}, 32'h0);
        chk("reset c_total", 32'(c_total), 32'h0);
        // 1: correctly predicted taken branch
        pkt(32'h100, 1, 1, 1, 0, 32'h140, 32'h104, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("t1 upd_valid", {31'b0, upd_valid}, 32'h1);
        chk("t1 upd_pc", upd_pc, 32'h100);
        chk("t1 upd_taken", {31'b0, upd_taken}, 32'h1);
        chk("t1 redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("t1 c_total", 32'(c_total), 32'h1);
        chk("t1 c_mispredict", 32'(c_mispredict), 32'h0);
        tick();
        chk("t1 upd one cycle", {31'b0, upd_valid}, 32'h0);
        // 2: mispredict with immediate handshake
        redirect_ready = 1'b1;
        pkt(32'h180, 1, 0, 1, 0, 32'h184, 32'h200, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("t2 redirect_pc", redirect_pc, 32'h200);
        chk("t2 c_mispredict", 32'(c_mispredict), 32'h1);
        fl = 0; rv = 0; rel = 0;
        for (int i = 1; i <= 6; i++) begin
            if (flush) fl++;
            if (redirect_valid) rv++;
            if (!stall_ex && rel == 0) rel = i;
            tick();
        end
        chk("t2 flush cycles", 32'(fl), 32'(1 + FC));
        chk("t2 redirect cycles", 32'(rv), 32'h1);
        chk("t2 stall release cycle", 32'(rel), 32'h4);
        // 3: held redirect with a second packet waiting
        redirect_ready = 1'b0;
        pkt(32'h300, 1, 1, 0, 0, 32'h340, 32'h304, 32'h0);
        tick();
        pkt(32'h400, 1, 0, 1, 0, 32'h404, 32'h500, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("t3 redirect_valid held", {31'b0, redirect_valid}, 32'h1);
            chk("t3 redirect_pc held", redirect_pc, 32'h304);
            if (i < 5) tick();
        end
        redirect_ready = 1'b1;
        ex_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t3 c_total", 32'(c_total), 32'h3);
        chk("t3 c_mispredict", 32'(c_mispredict), 32'h2);
        chk("t3 idle", {31'b0, stall_ex}, 32'h0);
        // 4: jalr redirects, jal does nothing
        pkt(32'h600, 0, 0, 0, 1, 32'h604, 32'h604, 32'h3FC);
        tick();
        ex_valid = 1'b0;
        chk("t4 jalr redirect_pc", redirect_pc, 32'h3FC);
        chk("t4 jalr upd_valid", {31'b0, upd_valid}, 32'h0);
        chk("t4 jalr c_total", 32'(c_total), 32'h3);
        tick(); tick(); tick();
        pkt(32'h700, 0, 0, 1, 0, 32'h800, 32'h704, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("t4 jal redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("t4 jal c_total", 32'(c_total), 32'h3);
        // 5: reset while redirecting
        redirect_ready = 1'b0;
        pkt(32'h900, 1, 0, 1, 0, 32'h904, 32'hA00, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("t5 in redirect", {31'b0, redirect_valid}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("t5 redirect_pc", redirect_pc, 32'h0);
        chk("t5 flush", {31'b0, flush}, 32'h0);
        chk("t5 c_total", 32'(c_total), 32'h0);
        pkt(32'hB00, 1, 0, 0, 0, 32'hB04, 32'hC00, 32'h0);
        tick();
        ex_valid = 1'b0;
        chk("t5 accepted upd_valid", {31'b0, upd_valid}, 32'h1);
        chk("t5 accepted c_total", 32'(c_total), 32'h1);
        // 6: saturation
        redirect_ready = 1'b1;
        reset_dut();
        for (int i = 0; i < SAT + 1; i++) begin
            pkt(32'h1000 + 32'(i * 4), 1, 1, 0, 0, 32'h2000, 32'h1004, 32'h0);
            tick();
            ex_valid = 1'b0;
            tick(); tick(); tick();
            if (i == SAT - 1) begin
                chk("t6 preload c_total", 32'(c_total), 32'(SAT));
                chk("t6 preload c_mispredict", 32'(c_mispredict), 32'(SAT));
            end
        end
        chk("t6 sat c_total", 32'(c_total), 32'hF);
        chk("t6 sat c_mispredict", 32'(c_mispredict), 32'hF);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Resolution end of the branch-prediction path. It consumes the prediction packet of a control-flow instruction in EX and compares it with the actual outcome.
- On a wrong prediction it redirects fetch and flushes younger instructions, then drains the pipeline.
- It returns a one-cycle training update to the direction predictor and keeps accuracy counters.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays asserted after the redirect handshake (0 allowed)
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset
ex_valid  in  1  EX holds a resolved br/jal/jalr this cycle
ex_pc  in  32  PC of the EX instruction
ex_predicted  in  1  packet carries a direction prediction (conditional branch)
ex_prediction  in  1  predicted direction
ex_target  in  32  PC fetch followed
ex_alt  in  32  the other candidate PC
ex_jalr  in  1  instruction is jalr (never predicted)
ex_jalr_target  in  32  computed jalr target, bit 0 already cleared
br_en  in  1  actual branch outcome
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  corrected fetch PC
redirect_ready  in  1  fetch accepts the redirect
flush  out  1  kill IF/ID contents
stall_ex  out  1  EX must hold; new packets are not accepted
upd_valid  out  1  predictor training pulse
upd_pc  out  32  PC to train
upd_taken  out  1  actual outcome to train with
c_total  out  CNT_W  predicted branches resolved
c_mispredict  out  CNT_W  predicted branches mispredicted

Behaviour:
- Reset is synchronous, active-high on rst; clock is clk.
- On reset:
  - All outputs are 0.
  - State goes to IDLE.
  - Counters clear.
  - A pending redirect is dropped.
- Reset mid-operation aborts from any state, even while redirect_valid is high; no handshake is required.
- Acceptance: a packet is accepted on a clk edge when ex_valid=1 and stall_ex=0. Packets with ex_valid=1 while stall_ex=1 are ignored; upstream must hold them.
- Mispredict decision, combinational on the accepted packet:
  - jalr: always redirect to ex_jalr_target.
  - ex_predicted=1: mispredict iff ex_prediction != br_en; redirect to ex_alt.
  - Otherwise (jal): never redirect.
- Training update: for an accepted packet with ex_predicted=1, the next cycle drives upd_valid=1 for exactly one cycle, with upd_pc=ex_pc and upd_taken=br_en. The update is issued whether or not the prediction was correct.
- Counters:
  - On each accepted ex_predicted=1 packet, c_total increments by 1.
  - c_mispredict also increments by 1 if the prediction was wrong.
  - Both counters saturate at all-ones; there is no wrap.
  - Counter values are visible one cycle after acceptance.
  - jal and jalr packets are not counted.
- States:
  - IDLE: stall_ex=0, flush=0, redirect_valid=0. An accepted packet that needs a redirect registers redirect_pc and moves to REDIRECT. Otherwise stay in IDLE, so back-to-back correct packets are accepted every cycle.
  - REDIRECT: redirect_valid=1, flush=1, stall_ex=1. redirect_pc is held stable until the handshake. On redirect_ready=1, go to DRAIN if FLUSH_CYCLES>0, else IDLE. A handshake in the first REDIRECT cycle is legal, giving minimum redirect latency of 1 cycle after acceptance.
  - DRAIN: redirect_valid=0, flush=1, stall_ex=1 for exactly FLUSH_CYCLES cycles, counted by an internal down-counter. Then go to IDLE. The first new packet can be accepted in the cycle IDLE is entered.
- redirect_ready is ignored outside REDIRECT.
- redirect_pc returns to 0 in IDLE.

Test Plan:
1. Reset, then predicted branch with ex_pc=0x100, prediction=1, br_en=1, target=0x140 -> no redirect; next cycle upd_valid=1, upd_pc=0x100, upd_taken=1; c_total=1, c_mispredict=0.
2. Prediction=0, br_en=1, ex_alt=0x200, redirect_ready held 1 -> redirect_valid=1 with redirect_pc=0x200 for 1 cycle; flush high for 1+2 cycles; stall_ex releases on cycle 4; c_mispredict=1.
3. Mispredict with redirect_ready=0 for 5 cycles, then 1 -> redirect_valid and redirect_pc stable all 6 cycles; a second ex_valid presented meanwhile is not accepted and not counted.
4. jalr with ex_jalr_target=0x3FC -> redirect to 0x3FC; upd_valid stays 0; c_total unchanged. jal packet -> no redirect, no count.
5. Assert rst while in REDIRECT -> next cycle all outputs 0, state IDLE; a following correct branch is accepted immediately.
6. Preload via 2^CNT_W-1 predicted mispredicts with CNT_W=4 (15 packets), then one more mispredict -> both counters hold 15.
